// File: rtl/spi_master_multi.sv
// spi_master_multi: SPI master with CPOL/CPHA modes, bit order, sck divider and NUM_SS selects.
// One DATA_W-bit word per trans_en; busy spans SETUP, XFER, HOLD and DONE.
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_config,
    input  logic              trans_en,
    input  logic [DATA_W-1:0] i_data_p,
    input  logic              irq_clr,
    output logic [DATA_W-1:0] o_data_p,
    output logic              busy,
    output logic              interupt_request,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);
    localparam int HPW = $clog2(2 * DATA_W);
    localparam logic [HPW-1:0] HP_LAST = HPW'(2 * DATA_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, DONE} state_t;

    function automatic logic [DATA_W-1:0] rev(input logic [DATA_W-1:0] v);
        logic [DATA_W-1:0] r;
        for (int i = 0; i < DATA_W; i++) r[i] = v[DATA_W-1-i];
        return r;
    endfunction

    state_t            state_q;
    logic [15:0]       div_q, cnt_q;
    logic              cpol_q, cpha_q, lsb_q, irq_en_q;
    logic [DATA_W-1:0] tx_q, rx_q, data_q;
    logic [HPW-1:0]    hp_q;
    logic              busy_q, sck_q, mosi_q, irq_q;
    logic [NUM_SS-1:0] ss_n_q;

    logic [3:0]        ss_sel;
    logic              accept, half_end, leading, unused_cfg;
    logic [DATA_W-1:0] tx_in;

    assign ss_sel     = data_config[22:19];
    assign accept     = trans_en && ({28'd0, ss_sel} < 32'(NUM_SS));
    assign half_end   = cnt_q == div_q;
    assign leading    = ~hp_q[0];
    assign tx_in      = data_config[18] ? rev(i_data_p) : i_data_p;
    assign unused_cfg = ^data_config[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            div_q    <= '0;
            cnt_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            irq_en_q <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            data_q   <= '0;
            hp_q     <= '0;
            busy_q   <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            irq_q    <= 1'b0;
            ss_n_q   <= '1;
        end else begin
            if (irq_clr) irq_q <= 1'b0;
            case (state_q)
                IDLE: if (accept) begin
                    state_q  <= SETUP;
                    busy_q   <= 1'b1;
                    cnt_q    <= '0;
                    hp_q     <= '0;
                    rx_q     <= '0;
                    div_q    <= data_config[15:0];
                    cpol_q   <= data_config[16];
                    cpha_q   <= data_config[17];
                    lsb_q    <= data_config[18];
                    irq_en_q <= data_config[23];
                    sck_q    <= data_config[16];
                    // tx_q always holds the next bit to emit in its MSB
                    tx_q     <= data_config[17] ? tx_in : tx_in << 1;
                    mosi_q   <= ~data_config[17] & tx_in[DATA_W-1];
                    ss_n_q   <= ~(NUM_SS'(1) << ss_sel);
                end
                SETUP: begin
                    cnt_q <= half_end ? '0 : cnt_q + 16'd1;
                    if (half_end) state_q <= XFER;
                end
                XFER: begin
                    cnt_q <= half_end ? '0 : cnt_q + 16'd1;
                    if (half_end) begin
                        sck_q <= ~sck_q;
                        hp_q  <= hp_q + HPW'(1);
                        if (leading ^ cpha_q) rx_q <= {rx_q[DATA_W-2:0], miso};
                        if (cpha_q ? leading : (!leading && hp_q != HP_LAST)) begin
                            mosi_q <= tx_q[DATA_W-1];
                            tx_q   <= tx_q << 1;
                        end
                        if (hp_q == HP_LAST) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    cnt_q <= half_end ? '0 : cnt_q + 16'd1;
                    if (half_end) begin
                        state_q <= DONE;
                        ss_n_q  <= '1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    mosi_q  <= 1'b0;
                    data_q  <= lsb_q ? rev(rx_q) : rx_q;
                    if (irq_en_q) irq_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_data_p         = data_q;
    assign busy             = busy_q;
    assign interupt_request = irq_q;
    assign sck              = sck_q;
    assign mosi             = mosi_q;
    assign ss_n             = ss_n_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// tb_spi_master_multi: randomized and directed transfers against a slave model and
// transfer-level expectations (lengths, edge counts, words, selects, irq).
module tb_spi_master_multi;
    localparam int W  = 8;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   data_config = '0;
    logic          trans_en = 1'b0;
    logic [W-1:0]  i_data_p = '0;
    logic          irq_clr = 1'b0;
    logic [W-1:0]  o_data_p;
    logic          busy, interupt_request, sck, mosi, miso;
    logic [NS-1:0] ss_n;

    spi_master_multi #(.DATA_W(W), .NUM_SS(NS)) dut (
        .clk(clk), .rst(rst), .data_config(data_config), .trans_en(trans_en),
        .i_data_p(i_data_p), .irq_clr(irq_clr), .o_data_p(o_data_p), .busy(busy),
        .interupt_request(interupt_request), .sck(sck), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave / monitor state
    logic          m_cpol = 0, m_cpha = 0, m_lsb = 0, loopback = 0, s_bit = 0;
    logic [W-1:0]  s_word = '0, cap = '0;
    logic [NS-1:0] ss_seen = '0;
    logic          sck_p = 0, ss_p = 0, act, lead;
    int cyc = 0, busy_n = 0, lead_n = 0, trail_n = 0, idle_edges = 0;
    int hp_min = 0, hp_max = 0, first_gap = 0, last_gap = 0, t_ss = 0, t_last = 0;
    int s_idx = 0, cap_idx = 0;
    logic irq_m = 0;

    assign miso = loopback ? mosi : s_bit;

    function automatic logic bit_of(input int k);
        if (k >= W) return 1'b0;
        return m_lsb ? s_word[k] : s_word[W-1-k];
    endfunction

    always @(negedge clk) begin
        act = (ss_n != '1);
        cyc++;
        if (busy) busy_n++;
        ss_seen |= ~ss_n;
        if (act && !ss_p) begin
            t_ss = cyc;
            t_last = -1;
            s_idx = 0;
            if (!m_cpha) s_bit = bit_of(0);
        end
        if (!act && ss_p) last_gap = cyc - t_last;
        if (act && ss_p && sck !== sck_p) begin
            lead = (sck !== m_cpol);
            if (t_last < 0) first_gap = cyc - t_ss;
            else begin
                if (cyc - t_last < hp_min) hp_min = cyc - t_last;
                if (cyc - t_last > hp_max) hp_max = cyc - t_last;
            end
            t_last = cyc;
            if (lead) lead_n++; else trail_n++;
            if (lead ^ m_cpha) begin
                if (cap_idx < W) cap[m_lsb ? cap_idx : W-1-cap_idx] = mosi;
                cap_idx++;
            end
            if (m_cpha && lead) begin
                s_bit = bit_of(s_idx);
                s_idx++;
            end else if (!m_cpha && !lead) begin
                s_idx++;
                s_bit = bit_of(s_idx);
            end
        end
        if (!act && !ss_p && sck !== sck_p) idle_edges++;
        sck_p = sck;
        ss_p = act;
    end

    task automatic clr_irq();
        @(negedge clk);
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        irq_m = 1'b0;
        check("irq_clr", interupt_request, 0);
    endtask

    // mode: 0 plain, 1 second request mid-transfer, 2 irq_clr during DONE, 3 reset mid-transfer
    task automatic xfer(input int div, input bit cpol, input bit cpha, input bit lsb, input int ss,
                        input bit ien, input logic [W-1:0] d, input logic [W-1:0] sw,
                        input bit lb, input int mode);
        int h;
        bit done;
        h = div + 1;
        done = 0;
        @(negedge clk);
        m_cpol = cpol; m_cpha = cpha; m_lsb = lsb; s_word = sw; loopback = lb;
        busy_n = 0; lead_n = 0; trail_n = 0; idle_edges = 0; cap = '0; cap_idx = 0;
        ss_seen = '0; hp_min = 1 << 30; hp_max = 0; first_gap = -1; last_gap = -1;
        data_config = {8'($urandom), ien, 4'(ss), lsb, cpha, cpol, 16'(div)};
        i_data_p = d;
        trans_en = 1'b1;
        @(negedge clk);
        trans_en = 1'b0;
        i_data_p = W'($urandom);
        if (ss >= NS) begin
            repeat (20) @(negedge clk);
            check("rej_busy", busy_n, 0);
            check("rej_ss", ss_seen, 0);
            check("rej_sck", idle_edges, 0);
            check("rej_irq", interupt_request, irq_m);
            return;
        end
        for (int i = 0; i < 3000; i++) begin
            if (!busy) begin
                done = 1;
                break;
            end
            if (mode == 1) begin
                trans_en = (i == 5);
                data_config[22:19] = 4'd1;
            end
            if (mode == 2) irq_clr = (ss_n == '1);
            if (mode == 3 && lead_n + trail_n == 6) begin
                rst = 1'b0;
                #1;
                check("rst_busy", busy, 0);
                check("rst_ss", ss_n, 4'hF);
                check("rst_sck", sck, 0);
                check("rst_mosi", mosi, 0);
                check("rst_data", o_data_p, 0);
                check("rst_irq", interupt_request, 0);
                irq_m = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                return;
            end
            @(negedge clk);
        end
        trans_en = 1'b0;
        irq_clr = 1'b0;
        check("done_in_time", done, 1);
        if (ien) irq_m = 1'b1;
        else if (mode == 2) irq_m = 1'b0;
        check("busy_len", busy_n, (2 * W + 2) * h + 1);
        check("rx_word", o_data_p, lb ? d : sw);
        check("mosi_word", cap, d);
        check("lead_edges", lead_n, W);
        check("trail_edges", trail_n, W);
        check("ss_sel", ss_seen, NS'(1) << ss);
        check("half_min", hp_min, h);
        check("half_max", hp_max, h);
        check("setup_gap", first_gap, 2 * h);
        check("hold_gap", last_gap, h);
        check("irq", interupt_request, irq_m);
        check("sck_idle", sck, cpol);
        check("mosi_idle", mosi, 0);
        check("ss_idle", ss_n, 4'hF);
        if (mode == 1) begin
            repeat (6) @(negedge clk);
            check("second_dropped", busy_n, (2 * W + 2) * h + 1);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_ss", ss_n, 4'hF);
        check("reset_sck", sck, 0);
        check("reset_mosi", mosi, 0);
        check("reset_data", o_data_p, 0);
        check("reset_irq", interupt_request, 0);
        rst = 1'b1;
        xfer(0, 0, 0, 0, 0, 1, 8'hA5, 8'h00, 1, 0);
        xfer(3, 1, 1, 1, 1, 0, W'($urandom), 8'h3C, 0, 0);
        xfer(1, 0, 1, 0, 2, 0, W'($urandom), W'($urandom), 0, 1);
        clr_irq();
        xfer(0, 0, 0, 0, 5, 1, W'($urandom), W'($urandom), 0, 0);
        xfer(0, 0, 0, 0, 3, 1, W'($urandom), W'($urandom), 0, 0);
        xfer(1, 1, 0, 1, 0, 1, W'($urandom), W'($urandom), 0, 2);
        clr_irq();
        xfer(2, 0, 0, 0, 1, 1, W'($urandom), W'($urandom), 0, 3);
        xfer(0, 0, 1, 1, 1, 1, W'($urandom), W'($urandom), 0, 0);
        for (int n = 0; n < 20; n++) begin
            xfer($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                 $urandom_range(0, NS - 1), 1'($urandom), W'($urandom), W'($urandom),
                 1'($urandom), 0);
            if ($urandom_range(0, 3) == 0) clr_irq();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
